// File: rtl/dna_port_ctrl.sv
// Device DNA readout controller.
// It drives the READ and SHIFT pins of a DNA_PORT-style primitive and collects
// the serial ID, MSB first, into a right-aligned 96-bit register.
module dna_port_ctrl #(
  parameter string FAMILY     = "7Series", // "7Series" -> 57-bit DNA, otherwise 96-bit
  parameter int    CLK_DIV    = 1,         // primitive shift rate divider, 1..255
  parameter int    AUTO_START = 1          // 1: start one read right after reset release
) (
  input  logic        s_axil_clk,
  input  logic        s_axil_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        dna_valid,
  output logic [95:0] dna_value,
  output logic [6:0]  dna_len,
  output logic        dna_read,
  output logic        dna_shift,
  input  logic        dna_dout
);

  localparam int         BITS     = (FAMILY == "7Series") ? 57 : 96;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] CNT_LAST = 7'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      prescaler;
  logic [6:0]      bit_cnt;
  // The final bit is taken straight from dna_dout on the last tick, so the
  // shift register only ever needs to hold BITS-1 earlier bits.
  logic [BITS-2:0] shreg;
  logic            auto_pend;
  logic            tick;
  logic            accept;
  logic            last_bit;

  assign dna_len  = 7'(BITS);
  assign tick     = (state != IDLE) && (prescaler == DIV_LAST);
  assign accept   = (state == IDLE) && (start || auto_pend);
  assign last_bit = (bit_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    if (s_axil_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the primitive strobes decoded from state and tick.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value held (no latch).
    state_next = state;
    dna_read   = 1'b0;
    dna_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_pend) state_next = LOAD;
      end
      LOAD: begin
        dna_read = tick;
        if (tick) state_next = SHIFT;
      end
      SHIFT: begin
        dna_shift = tick;
        if (tick && last_bit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler, bit capture, and the registered status outputs.
  always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      // NOTE: the wide capture register is reset as well, because dna_value
      // must read zero from the moment reset is asserted.
      prescaler <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      auto_pend <= (AUTO_START != 0);
      busy      <= 1'b0;
      done      <= 1'b0;
      dna_valid <= 1'b0;
      dna_value <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);

      // Divider runs only while a read is in flight and wraps on each tick.
      if (state == IDLE || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 8'd1;
      end

      // A new read invalidates the old result but leaves it visible.
      if (accept) begin
        auto_pend <= 1'b0;
        dna_valid <= 1'b0;
        bit_cnt   <= '0;
        shreg     <= '0;
      end

      if (state == SHIFT && tick) begin
        shreg   <= {shreg[BITS-3:0], dna_dout};
        bit_cnt <= bit_cnt + 7'd1;
        if (last_bit) begin
          dna_value <= 96'({shreg, dna_dout});
          dna_valid <= 1'b1;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dna_port_ctrl.sv
// Testbench for dna_port_ctrl: two instances (57-bit /1 auto-start and
// 96-bit /2 manual start) each attached to a behavioural DNA primitive.
module tb_dna_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: posedge blocks see the index of the current edge; at a
  // negedge cyc equals (index of the last edge) + 1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic        rst   [2];
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic        valid [2];
  logic [95:0] value [2];
  logic [6:0]  len   [2];
  logic        rd    [2];
  logic        sh    [2];
  logic        dout  [2];

  dna_port_ctrl #(.FAMILY("7Series"), .CLK_DIV(1), .AUTO_START(1)) u_a (
    .s_axil_clk(clk), .s_axil_rst(rst[0]), .start(start[0]), .busy(busy[0]),
    .done(done[0]), .dna_valid(valid[0]), .dna_value(value[0]), .dna_len(len[0]),
    .dna_read(rd[0]), .dna_shift(sh[0]), .dna_dout(dout[0])
  );

  dna_port_ctrl #(.FAMILY("UltraScale"), .CLK_DIV(2), .AUTO_START(0)) u_b (
    .s_axil_clk(clk), .s_axil_rst(rst[1]), .start(start[1]), .busy(busy[1]),
    .done(done[1]), .dna_valid(valid[1]), .dna_value(value[1]), .dna_len(len[1]),
    .dna_read(rd[1]), .dna_shift(sh[1]), .dna_dout(dout[1])
  );

  function automatic int bits_of(input int d);
    return (d == 0) ? 57 : 96;
  endfunction

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [95:0] expect_val(input int d, input logic [95:0] id);
    logic [95:0] one;
    one = 96'd1;
    if (bits_of(d) == 96) return id;
    return id & ((one << bits_of(d)) - one);
  endfunction

  // Behavioural DNA primitive: READ loads the ID, SHIFT moves it left,
  // DOUT is the MSB of the BITS-wide register.
  logic [95:0] prim_id    [2] = '{default: '0};
  logic [95:0] prim_sr    [2] = '{default: '0};
  int          read_cnt   [2] = '{default: 0};
  int          shift_cnt  [2] = '{default: 0};
  int          space_err  [2] = '{default: 0};
  int          last_shift [2] = '{-1, -1};

  always_comb begin
    for (int g = 0; g < 2; g++) dout[g] = prim_sr[g][bits_of(g)-1];
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd[g]) begin
        prim_sr[g]    <= prim_id[g];
        read_cnt[g]   <= read_cnt[g] + 1;
        last_shift[g] <= -1;
      end else if (sh[g]) begin
        prim_sr[g]   <= prim_sr[g] << 1;
        shift_cnt[g] <= shift_cnt[g] + 1;
        if (last_shift[g] >= 0 && (cyc - last_shift[g]) != div_of(g))
          space_err[g] <= space_err[g] + 1;
        last_shift[g] <= cyc;
      end
    end
  end

  task automatic check_val(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for done; optionally drive start with pulses at the given
  // negedge offsets. Counts cycles where busy dropped before done.
  task automatic wait_done(input int d, input bit drive, input int p1, input int p2,
                           output bit got, output int de, output int gap);
    got = 1'b0;
    de  = 0;
    gap = 0;
    for (int i = 1; i <= 1000 && !got; i++) begin
      @(negedge clk);
      if (drive) start[d] = (i == p1) || (i == p2);
      if (done[d]) begin
        got = 1'b1;
        de  = cyc - 1;
      end else if (!busy[d]) begin
        gap++;
      end
    end
  endtask

  // One complete read, launched at the current negedge by a start pulse or
  // by reset release (auto start), checked against the reference model.
  task automatic run_read(input int d, input logic [95:0] id, input bit by_start,
                          input int p1, input int p2, input string tag);
    int rc0, sc0, se0, e0, de, gap;
    bit got;
    prim_id[d] = id;
    rc0 = read_cnt[d];
    sc0 = shift_cnt[d];
    se0 = space_err[d];
    e0  = cyc;
    if (by_start) start[d] = 1'b1;
    else          rst[d]   = 1'b0;
    wait_done(d, 1'b1, p1, p2, got, de, gap);
    start[d] = 1'b0;
    check_int($sformatf("%s done_seen", tag), int'(got), 1);
    check_int($sformatf("%s latency", tag), de - e0, (bits_of(d) + 1) * div_of(d));
    check_val($sformatf("%s value", tag), value[d], expect_val(d, id));
    check_int($sformatf("%s valid", tag), int'(valid[d]), 1);
    check_int($sformatf("%s len", tag), int'(len[d]), bits_of(d));
    check_int($sformatf("%s reads", tag), read_cnt[d] - rc0, 1);
    check_int($sformatf("%s shifts", tag), shift_cnt[d] - sc0, bits_of(d));
    check_int($sformatf("%s shift_spacing", tag), space_err[d] - se0, 0);
    check_int($sformatf("%s busy_gaps", tag), gap, 0);
    @(negedge clk);
    check_int($sformatf("%s done_width", tag), int'(done[d]), 0);
    check_int($sformatf("%s valid_hold", tag), int'(valid[d]), 1);
    check_int($sformatf("%s no_requeue", tag), int'(busy[d]), 0);
  endtask

  typedef struct {
    int          d;
    logic [95:0] id;
    int          poke1;
    int          poke2;
    logic [95:0] exp_value;
    int          exp_lat;
  } vec_t;

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs [5];
    int          rc0, sc0, e0, de, de2, gap, bh;
    bit          got;
    logic [95:0] id;

    vecs[0] = '{0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 0, 96'h0000_0000_01FF_FFFF_FFFF_FFFF, 58};
    vecs[1] = '{0, 96'h0, 0, 0, 96'h0, 58};
    vecs[2] = '{0, 96'h0000_0000_0155_5555_5555_5555, 5, 40, 96'h0000_0000_0155_5555_5555_5555, 58};
    vecs[3] = '{1, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 194};
    vecs[4] = '{1, 96'h8000_0000_0000_0000_0000_0001, 7, 100, 96'h8000_0000_0000_0000_0000_0001, 194};

    rst[0] = 1'b1; rst[1] = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      check_int($sformatf("rst%0d busy", d), int'(busy[d]), 0);
      check_int($sformatf("rst%0d done", d), int'(done[d]), 0);
      check_int($sformatf("rst%0d valid", d), int'(valid[d]), 0);
      check_val($sformatf("rst%0d value", d), value[d], 96'h0);
      check_int($sformatf("rst%0d strobes", d), int'(rd[d]) + int'(sh[d]), 0);
      check_int($sformatf("rst%0d len", d), int'(len[d]), bits_of(d));
    end

    // 57-bit auto start on reset release.
    run_read(0, 96'h0000_0000_0010_2030_4050_6070, 1'b0, 0, 0, "auto57");
    check_val("auto57 exact", value[0], 96'h000000000010203040506070);

    // Manual-start instance stays silent after reset until asked.
    rc0 = read_cnt[1];
    sc0 = shift_cnt[1];
    rst[1] = 1'b0;
    bh = 0;
    repeat (500) begin
      @(negedge clk);
      if (busy[1]) bh++;
    end
    check_int("noauto reads", read_cnt[1] - rc0, 0);
    check_int("noauto shifts", shift_cnt[1] - sc0, 0);
    check_int("noauto busy", bh, 0);

    // 96-bit read at divide-by-2.
    run_read(1, 96'h0123_4567_89AB_CDEF_0123_4567, 1'b1, 0, 0, "us96");

    // Table of reads, including start re-pulsed mid-read.
    for (int v = 0; v < 5; v++) begin
      run_read(vecs[v].d, vecs[v].id, 1'b1, vecs[v].poke1, vecs[v].poke2, $sformatf("vec%0d", v));
      check_val($sformatf("vec%0d table_value", v), value[vecs[v].d], vecs[v].exp_value);
      check_int($sformatf("vec%0d table_lat", v), (bits_of(vecs[v].d) + 1) * div_of(vecs[v].d), vecs[v].exp_lat);
    end

    // Start held high through the done cycle: re-accepted immediately.
    id = 96'h0000_0000_00AB_CDEF_1234_5678;
    prim_id[0] = id;
    rc0 = read_cnt[0];
    start[0] = 1'b1;
    e0 = cyc;
    wait_done(0, 1'b0, 0, 0, got, de, gap);
    check_int("hold first_done", int'(got), 1);
    check_int("hold first_lat", de - e0, 58);
    check_val("hold first_value", value[0], id);
    @(negedge clk);
    check_int("hold valid_drop", int'(valid[0]), 0);
    check_val("hold value_kept", value[0], id);
    check_int("hold busy_again", int'(busy[0]), 1);
    start[0] = 1'b0;
    wait_done(0, 1'b1, 0, 0, got, de2, gap);
    check_int("hold second_done", int'(got), 1);
    check_int("hold second_lat", de2 - (de + 1), 58);
    check_val("hold second_value", value[0], id);
    check_int("hold second_valid", int'(valid[0]), 1);
    check_int("hold reads", read_cnt[0] - rc0, 2);
    @(negedge clk);

    // Reset in the middle of a read, then auto restart.
    prim_id[0] = 96'h0000_0000_0133_3333_3333_3333;
    sc0 = shift_cnt[0];
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (shift_cnt[0] - sc0 == 30) got = 1'b1;
      else @(negedge clk);
    end
    check_int("abort reached_30", int'(got), 1);
    check_int("abort busy_before", int'(busy[0]), 1);
    rst[0] = 1'b1;
    #1;
    check_int("abort busy", int'(busy[0]), 0);
    check_int("abort done", int'(done[0]), 0);
    check_int("abort valid", int'(valid[0]), 0);
    check_val("abort value", value[0], 96'h0);
    check_int("abort read", int'(rd[0]), 0);
    check_int("abort shift", int'(sh[0]), 0);
    check_int("abort len", int'(len[0]), 57);
    @(negedge clk);
    check_int("abort no_done", int'(done[0]), 0);
    run_read(0, 96'h0000_0000_01DE_ADBE_EFCA_FE12, 1'b0, 0, 0, "restart");

    // Randomized reads against the reference model.
    for (int r = 0; r < 8; r++) begin
      int d;
      d  = int'($urandom_range(0, 1));
      id = {$urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_read(d, id, 1'b1, int'($urandom_range(2, 50)), 0, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
